uart_tx_sched: RTL and testbench

Transmit scheduler in front of the `uart_TX` serializer. It shares the single UART transmitter between two requesters: a byte source (A, e.g. register-file read data) and a word source (B, e.g. a 2×DATA_W ALU result sent low byte first). It registers each request and drives `p_data`, `data_valid`, `par_en` and `par_type` into the transmitter. It then tracks the transmitter's `BUSY` output until every byte of the transaction has been serialized.

---
 rtl/uart_tx_sched.sv | 138 +++++++++++++
 tb/tb_uart_tx_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_tx_sched
// Brief   : Shares one uart_TX between a byte source (A) and a 2-byte word
//           source (B, low byte first). Define UART_TX_SCHED_RR_EN for
//           round-robin tie-breaking; otherwise A has fixed priority.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [DATA_W-1:0]     data_a,
  output logic                  ack_a,
  input  logic                  req_b,
  input  logic [2*DATA_W-1:0]   data_b,
  output logic                  ack_b,
  input  logic                  par_en_cfg,
  input  logic                  par_type_cfg,
  input  logic                  tx_busy,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_valid,
  output logic                  par_en,
  output logic                  par_type,
  output logic                  sched_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT_H = 2'd2,
    ST_WAIT_L = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2*DATA_W-1:0]   hold_q, hold_d;
  logic                  idx_q, idx_d;
  logic                  is_b_q, is_b_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic                  grant;
  logic                  grant_b;

  assign grant = (state_q == ST_IDLE) && (req_a || req_b) && !tx_busy;

`ifdef UART_TX_SCHED_RR_EN
  logic last_b_q, last_b_d;

  // On a tie the requester that was not granted last wins.
  assign grant_b  = req_b && (!req_a || !last_b_q);
  assign last_b_d = grant ? grant_b : last_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  assign grant_b = req_b && !req_a;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    is_b_d     = is_b_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d    = ST_LOAD;
          hold_d     = grant_b ? data_b : {{DATA_W{1'b0}}, data_a};
          is_b_d     = grant_b;
          idx_d      = 1'b0;
          par_en_d   = par_en_cfg;
          par_type_d = par_type_cfg;
          ack_a_d    = !grant_b;
          ack_b_d    = grant_b;
        end
      end
      ST_LOAD:   state_d = ST_WAIT_H;
      ST_WAIT_H: if (tx_busy) state_d = ST_WAIT_L;
      ST_WAIT_L: begin
        if (!tx_busy) begin
          // Second pass of a word sends the high byte without re-arbitrating.
          if (is_b_q && !idx_q) begin
            idx_d   = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      idx_q      <= 1'b0;
      is_b_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      is_b_q     <= is_b_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
    end
  end

  assign p_data     = idx_q ? hold_q[2*DATA_W-1:DATA_W] : hold_q[DATA_W-1:0];
  assign data_valid = (state_q == ST_LOAD);
  assign sched_busy = (state_q != ST_IDLE);
  assign par_en     = par_en_q;
  assign par_type   = par_type_q;
  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// Bench for uart_tx_sched: directed vector table, hand-written corner sequences
// and random traffic, all checked every cycle against a transaction-level model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [7:0]  data_a;
  logic [15:0] data_b;
  logic        par_en_cfg, par_type_cfg;
  logic        tx_busy;
  logic [7:0]  p_data;
  logic        data_valid, ack_a, ack_b, par_en, par_type, sched_busy;

  logic        auto_busy  = 1'b1;
  logic        ext_busy   = 1'b0;
  logic        model_busy = 1'b0;
  int          raise_delay = 1;
  int          frame_len   = 11;
  int          rise_cnt    = 0;
  int          busy_cnt    = 0;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [7:0]  got_bytes[$];
  logic        got_pe[$];
  logic        got_pt[$];
  logic        got_grants[$];

  assign tx_busy = auto_busy ? model_busy : ext_busy;

  always #5 clk = ~clk;

  uart_tx_sched #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .par_en_cfg(par_en_cfg), .par_type_cfg(par_type_cfg),
    .tx_busy(tx_busy), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_type(par_type), .sched_busy(sched_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: BUSY rises raise_delay cycles after a load strobe
  // and stays high for frame_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end else if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) begin
          model_busy = 1'b1;
          busy_cnt   = frame_len;
        end
      end
      if (data_valid && auto_busy) begin
        if (raise_delay == 0) begin
          model_busy = 1'b1;
          busy_cnt   = frame_len;
        end else begin
          rise_cnt = raise_delay;
        end
      end
    end
  end

  // Reference model: a transaction is a queue of bytes to load; one byte is
  // loaded, then BUSY must be seen high and then low before the next step.
  logic [7:0]  m_q[$];
  logic        m_free = 1'b1, m_loaded = 1'b0, m_rose = 1'b0, m_last_b = 1'b1;
  logic        e_dv, e_ack_a, e_ack_b;
  logic        e_pe = 1'b0, e_pt = 1'b0;
  logic [7:0]  e_pd = 8'h00;
  logic        s_rst, s_a, s_b, s_busy, s_pe, s_pt, pick_b, a_tie;
  logic [7:0]  s_da;
  logic [15:0] s_db;

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst;   s_a = req_a;   s_b = req_b;   s_busy = tx_busy;
      s_da  = data_a; s_db = data_b; s_pe = par_en_cfg; s_pt = par_type_cfg;
      #1;
      e_dv = 1'b0; e_ack_a = 1'b0; e_ack_b = 1'b0;
      if (!s_rst) begin
        m_q.delete();
        m_free = 1'b1; m_loaded = 1'b0; m_rose = 1'b0; m_last_b = 1'b1;
        e_pd = 8'h00; e_pe = 1'b0; e_pt = 1'b0;
      end else if (m_free) begin
        if ((s_a || s_b) && !s_busy) begin
`ifdef UART_TX_SCHED_RR_EN
          a_tie = m_last_b;
`else
          a_tie = 1'b1;
`endif
          pick_b   = s_b && !(s_a && a_tie);
          m_last_b = pick_b;
          m_q.delete();
          if (pick_b) begin
            m_q.push_back(s_db[7:0]);
            m_q.push_back(s_db[15:8]);
          end else begin
            m_q.push_back(s_da);
          end
          e_pd = m_q.pop_front();
          e_pe = s_pe; e_pt = s_pt;
          e_dv = 1'b1; e_ack_a = !pick_b; e_ack_b = pick_b;
          m_free = 1'b0; m_loaded = 1'b1; m_rose = 1'b0;
        end
      end else if (m_loaded) begin
        m_loaded = 1'b0;
      end else if (!m_rose) begin
        if (s_busy) m_rose = 1'b1;
      end else if (!s_busy) begin
        if (m_q.size() > 0) begin
          e_pd = m_q.pop_front();
          e_dv = 1'b1; m_loaded = 1'b1; m_rose = 1'b0;
        end else begin
          m_free = 1'b1;
        end
      end
      chk("data_valid", 32'(data_valid), 32'(e_dv));
      chk("ack_a",      32'(ack_a),      32'(e_ack_a));
      chk("ack_b",      32'(ack_b),      32'(e_ack_b));
      chk("sched_busy", 32'(sched_busy), 32'(!m_free));
      chk("p_data",     32'(p_data),     32'(e_pd));
      chk("par_en",     32'(par_en),     32'(e_pe));
      chk("par_type",   32'(par_type),   32'(e_pt));
      if (data_valid) begin
        got_bytes.push_back(p_data);
        got_pe.push_back(par_en);
        got_pt.push_back(par_type);
      end
      if (ack_a) got_grants.push_back(1'b0);
      if (ack_b) got_grants.push_back(1'b1);
    end
  end

  task automatic clear_got();
    got_bytes.delete(); got_pe.delete(); got_pt.delete(); got_grants.delete();
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (!sched_busy && !tx_busy && rise_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic wait_ack();
    logic ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ack_a || ack_b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_timeout", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic        ra, rb;
    logic [7:0]  da;
    logic [15:0] db;
    logic        pe, pt;
    int          rd, fl;
    logic        exp_b;
    int          nbytes;
    logic [7:0]  b0, b1;
  } vec_t;

  vec_t vecs[7];
  logic exp_order[4];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'hCA, 16'h0000, 1'b1, 1'b0, 1, 11, 1'b0, 1, 8'hCA, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b1, 1, 11, 1'b1, 2, 8'h34, 8'h12};
    vecs[2] = '{1'b1, 1'b0, 8'h5A, 16'h0000, 1'b1, 1'b1, 0, 3,  1'b0, 1, 8'h5A, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 16'hBEEF, 1'b1, 1'b0, 3, 5,  1'b1, 2, 8'hEF, 8'hBE};
    vecs[4] = '{1'b1, 1'b1, 8'h11, 16'h2233, 1'b0, 1'b0, 1, 4,  1'b0, 1, 8'h11, 8'h00};
`ifdef UART_TX_SCHED_RR_EN
    vecs[5] = '{1'b1, 1'b1, 8'h44, 16'h6677, 1'b1, 1'b1, 2, 6,  1'b1, 2, 8'h77, 8'h66};
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    vecs[5] = '{1'b1, 1'b1, 8'h44, 16'h6677, 1'b1, 1'b1, 2, 6,  1'b0, 1, 8'h44, 8'h00};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    vecs[6] = '{1'b1, 1'b1, 8'h88, 16'h99AA, 1'b0, 1'b1, 1, 2,  1'b0, 1, 8'h88, 8'h00};

    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 16'h0000;
    par_en_cfg = 1'b0; par_type_cfg = 1'b0;
    tick(); tick();
    chk("reset_p_data",     32'(p_data),     32'd0);
    chk("reset_sched_busy", 32'(sched_busy), 32'd0);
    rst = 1'b1;
    tick(); tick();

    // Directed single transactions
    for (int i = 0; i < 7; i++) begin
      raise_delay = vecs[i].rd; frame_len = vecs[i].fl;
      clear_got();
      req_a = vecs[i].ra; req_b = vecs[i].rb;
      data_a = vecs[i].da; data_b = vecs[i].db;
      par_en_cfg = vecs[i].pe; par_type_cfg = vecs[i].pt;
      wait_ack();
      req_a = 1'b0; req_b = 1'b0;
      par_en_cfg = !vecs[i].pe; par_type_cfg = !vecs[i].pt;
      wait_idle();
      chk("vec_grants", 32'(got_grants.size()), 32'd1);
      if (got_grants.size() > 0) chk("vec_winner", 32'(got_grants[0]), 32'(vecs[i].exp_b));
      chk("vec_nbytes", 32'(got_bytes.size()), 32'(vecs[i].nbytes));
      for (int j = 0; j < got_bytes.size() && j < 2; j++) begin
        chk("vec_byte", 32'(got_bytes[j]), 32'((j == 0) ? vecs[i].b0 : vecs[i].b1));
        chk("vec_par_en", 32'(got_pe[j]), 32'(vecs[i].pe));
        chk("vec_par_type", 32'(got_pt[j]), 32'(vecs[i].pt));
      end
    end

    // Reset during the low byte of a word
    raise_delay = 1; frame_len = 11;
    req_b = 1'b1; data_b = 16'hA55A; par_en_cfg = 1'b1; par_type_cfg = 1'b1;
    wait_ack();
    req_b = 1'b0;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (tx_busy) begin
          seen = 1'b1;
          break;
        end
      end
      chk("midb_busy_timeout", 32'(seen), 32'd1);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("midb_p_data",     32'(p_data),     32'd0);
    chk("midb_data_valid", 32'(data_valid), 32'd0);
    chk("midb_ack_a",      32'(ack_a),      32'd0);
    chk("midb_ack_b",      32'(ack_b),      32'd0);
    chk("midb_par_en",     32'(par_en),     32'd0);
    chk("midb_par_type",   32'(par_type),   32'd0);
    chk("midb_sched_busy", 32'(sched_busy), 32'd0);
    tick(); tick();
    rst = 1'b1;
    clear_got();
    repeat (20) tick();
    chk("midb_no_grant", 32'(got_grants.size()), 32'd0);
    chk("midb_no_load",  32'(got_bytes.size()),  32'd0);
    wait_idle();

    // Both requests held from reset
    rst = 1'b0; raise_delay = 1; frame_len = 3;
    req_a = 1'b1; data_a = 8'h77; req_b = 1'b1; data_b = 16'h9988;
    tick(); tick();
    clear_got();
    rst = 1'b1;
    begin
      logic done = 1'b0;
      for (int k = 0; k < 400; k++) begin
        tick();
        if (got_grants.size() >= 4) begin
          done = 1'b1;
          break;
        end
      end
      chk("tie_timeout", 32'(done), 32'd1);
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle();
    for (int j = 0; j < 4; j++)
      if (j < got_grants.size()) chk("tie_order", 32'(got_grants[j]), 32'(exp_order[j]));

    // Grant blocked by an already-busy transmitter
    auto_busy = 1'b0; ext_busy = 1'b1;
    clear_got();
    req_a = 1'b1; data_a = 8'h3C; par_en_cfg = 1'b0; par_type_cfg = 1'b1;
    repeat (5) tick();
    chk("blocked_ack", 32'(got_grants.size()), 32'd0);
    chk("blocked_dv",  32'(got_bytes.size()),  32'd0);
    ext_busy = 1'b0;
    tick();
    chk("unblock_ack_a", 32'(ack_a),      32'd1);
    chk("unblock_dv",    32'(data_valid), 32'd1);
    chk("unblock_pdata", 32'(p_data),     32'h3C);
    req_a = 1'b0;
    ext_busy = 1'b1;
    tick(); tick();
    ext_busy = 1'b0;
    wait_idle();
    auto_busy = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      raise_delay = $urandom_range(0, 3);
      frame_len   = $urandom_range(2, 12);
      if (req_a && ack_a) req_a = 1'b0;
      if (req_b && ack_b) req_b = 1'b0;
      if (!req_a) begin
        data_a = 8'($urandom);
        if ($urandom_range(0, 3) == 0) req_a = 1'b1;
      end
      if (!req_b) begin
        data_b = 16'($urandom);
        if ($urandom_range(0, 3) == 0) req_b = 1'b1;
      end
      par_en_cfg   = 1'($urandom);
      par_type_cfg = 1'($urandom);
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
